// File: rtl/lbc_encoder_tx.sv
// (13,8) linear block code transmitter: byte in over valid/ready, codeword out in
// parallel and as a framed serial stream. Optional ENC_ERR_INJECT_EN adds err_mask_i.
`timescale 1ns / 1ps

module lbc_encoder_tx #(
  parameter int unsigned IDLE_GAP  = 0,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  d_i,
  input  logic        d_valid_i,
`ifdef ENC_ERR_INJECT_EN
  input  logic [12:0] err_mask_i,
`endif
  output logic        d_ready_o,
  output logic [12:0] cx_o,
  output logic        cx_valid_o,
  output logic        sout_o,
  output logic        sout_valid_o,
  output logic        sout_sof_o,
  output logic        busy_o
);

  localparam bit          HasGap  = (IDLE_GAP > 0);
  localparam int unsigned GapW    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GapW-1:0] GapLast = HasGap ? GapW'(IDLE_GAP - 1) : '0;
  localparam logic [3:0]  LastBit = 4'd12;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [GapW-1:0]   gap_q;
  logic [12:0]       shreg_q;
  logic [12:0]       cx_q;
  logic              cx_valid_q;
  logic              sout_q;
  logic              sout_valid_q;
  logic              sout_sof_q;

  logic [12:0]       cw;
  logic              xfer;
  logic              load_bit;
  logic [12:0]       load_sh;
  logic              next_bit;
  logic [12:0]       next_sh;

  always_comb begin
    cw       = '0;
    cw[7:0]  = d_i;
    cw[8]    = d_i[0] ^ d_i[1] ^ d_i[2] ^ d_i[4] ^ d_i[5] ^ d_i[6];
    cw[9]    = d_i[0] ^ d_i[1] ^ d_i[6];
    cw[10]   = d_i[4] ^ d_i[6];
    cw[11]   = d_i[2] ^ d_i[3] ^ d_i[4];
    cw[12]   = d_i[0];
`ifdef ENC_ERR_INJECT_EN
    cw       = cw ^ err_mask_i;
`endif
  end

  // The first bit goes straight to sout; the shift register holds the rest.
  always_comb begin
    load_bit = LSB_FIRST ? cw[0] : cw[12];
    load_sh  = LSB_FIRST ? {1'b0, cw[12:1]} : {cw[11:0], 1'b0};
    next_bit = LSB_FIRST ? shreg_q[0] : shreg_q[12];
    next_sh  = LSB_FIRST ? {1'b0, shreg_q[12:1]} : {shreg_q[11:0], 1'b0};
  end

  always_comb begin
    d_ready_o = (state_q == StIdle) ||
                (!HasGap && (state_q == StShift) && (cnt_q == LastBit));
    xfer      = d_valid_i && d_ready_o;
    busy_o    = (state_q != StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      gap_q        <= '0;
      shreg_q      <= '0;
      cx_q         <= '0;
      cx_valid_q   <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_sof_q   <= 1'b0;
    end else begin
      cx_valid_q <= 1'b0;
      if (xfer) begin
        state_q      <= StShift;
        cnt_q        <= '0;
        shreg_q      <= load_sh;
        cx_q         <= cw;
        cx_valid_q   <= 1'b1;
        sout_q       <= load_bit;
        sout_valid_q <= 1'b1;
        sout_sof_q   <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_sof_q   <= 1'b0;
          end
          StShift: begin
            sout_sof_q <= 1'b0;
            if (cnt_q == LastBit) begin
              sout_q       <= 1'b0;
              sout_valid_q <= 1'b0;
              gap_q        <= '0;
              state_q      <= HasGap ? StGap : StIdle;
            end else begin
              cnt_q   <= cnt_q + 4'd1;
              sout_q  <= next_bit;
              shreg_q <= next_sh;
            end
          end
          StGap: begin
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_sof_q   <= 1'b0;
            if (gap_q == GapLast) begin
              state_q <= StIdle;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: begin
            state_q      <= StIdle;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_sof_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cx_o         = cx_q;
  assign cx_valid_o   = cx_valid_q;
  assign sout_o       = sout_q;
  assign sout_valid_o = sout_valid_q;
  assign sout_sof_o   = sout_sof_q;

endmodule

// File: tb/tb_lbc_encoder_tx.sv
// Directed bench for lbc_encoder_tx: one back-to-back LSB-first instance and one
// instance with a 3-cycle gap and MSB-first order.
`timescale 1ns / 1ps

module tb_lbc_encoder_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst0, dv0, rdy0, cxv0, so0, sov0, sof0, busy0;
  logic [7:0]  d0;
  logic [12:0] cx0;
  logic        rst1, dv1, rdy1, cxv1, so1, sov1, sof1, busy1;
  logic [7:0]  d1;
  logic [12:0] cx1;
`ifdef ENC_ERR_INJECT_EN
  logic [12:0] em0 = '0;
  logic [12:0] em1 = '0;
`endif

  lbc_encoder_tx #(.IDLE_GAP(0), .LSB_FIRST(1'b1)) dut0 (
    .clk_i        (clk),
    .rst_i        (rst0),
    .d_i          (d0),
    .d_valid_i    (dv0),
`ifdef ENC_ERR_INJECT_EN
    .err_mask_i   (em0),
`endif
    .d_ready_o    (rdy0),
    .cx_o         (cx0),
    .cx_valid_o   (cxv0),
    .sout_o       (so0),
    .sout_valid_o (sov0),
    .sout_sof_o   (sof0),
    .busy_o       (busy0)
  );

  lbc_encoder_tx #(.IDLE_GAP(3), .LSB_FIRST(1'b0)) dut1 (
    .clk_i        (clk),
    .rst_i        (rst1),
    .d_i          (d1),
    .d_valid_i    (dv1),
`ifdef ENC_ERR_INJECT_EN
    .err_mask_i   (em1),
`endif
    .d_ready_o    (rdy1),
    .cx_o         (cx1),
    .cx_valid_o   (cxv1),
    .sout_o       (so1),
    .sout_valid_o (sov1),
    .sout_sof_o   (sof1),
    .busy_o       (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample point of frame cycle 0; returns at the sample point of cycle 12.
  task automatic frame0(input string tag, input logic [12:0] cw);
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("%s_sov%0d", tag, k), sov0, 1'b1);
      chk($sformatf("%s_bit%0d", tag, k), so0, cw[k]);
      chk($sformatf("%s_sof%0d", tag, k), sof0, (k == 0));
      chk($sformatf("%s_cxv%0d", tag, k), cxv0, (k == 0));
      chk($sformatf("%s_rdy%0d", tag, k), rdy0, (k == 12));
      chk($sformatf("%s_cx%0d", tag, k), cx0, cw);
      if (k < 12) step();
    end
  endtask

  task automatic frame1(input string tag, input logic [12:0] cw);
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("%s_sov%0d", tag, k), sov1, 1'b1);
      chk($sformatf("%s_bit%0d", tag, k), so1, cw[12 - k]);
      chk($sformatf("%s_sof%0d", tag, k), sof1, (k == 0));
      chk($sformatf("%s_rdy%0d", tag, k), rdy1, 1'b0);
      chk($sformatf("%s_cx%0d", tag, k), cx1, cw);
      if (k < 12) step();
    end
  endtask

  task automatic idle0(input string tag, input logic [12:0] cw);
    chk({tag, "_sov"}, sov0, 1'b0);
    chk({tag, "_so"}, so0, 1'b0);
    chk({tag, "_sof"}, sof0, 1'b0);
    chk({tag, "_busy"}, busy0, 1'b0);
    chk({tag, "_rdy"}, rdy0, 1'b1);
    chk({tag, "_cx"}, cx0, cw);
  endtask

  logic [7:0]  vec_d  [4];
  logic [12:0] vec_cw [4];

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    dv0 = 1'b0; dv1 = 1'b0; d0 = '0; d1 = '0;
    vec_d[0] = 8'h80; vec_cw[0] = 13'h0080;
    vec_d[1] = 8'h10; vec_cw[1] = 13'h0D10;
    vec_d[2] = 8'h40; vec_cw[2] = 13'h0740;
    vec_d[3] = 8'h08; vec_cw[3] = 13'h0808;
    step();
    step();
    chk("rst_cx", cx0, 13'h0);
    chk("rst_cxv", cxv0, 1'b0);
    chk("rst_so", so0, 1'b0);
    chk("rst_sov", sov0, 1'b0);
    chk("rst_sof", sof0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst1_busy", busy1, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0;
    step();
    chk("rel_rdy", rdy0, 1'b1);
    chk("rel_rdy1", rdy1, 1'b1);

    // d=00
    d0 = 8'h00; dv0 = 1'b1;
    step();
    dv0 = 1'b0;
    frame0("d00", 13'h0000);
    step();
    idle0("d00_end", 13'h0000);

    // d=01, LSB first
    d0 = 8'h01; dv0 = 1'b1;
    step();
    dv0 = 1'b0;
    chk("d01_busy", busy0, 1'b1);
    frame0("d01", 13'h1301);
    step();
    idle0("d01_end", 13'h1301);
    step();
    idle0("d01_hold", 13'h1301);

    // Reset pulse while idle clears cx too
    rst0 = 1'b1;
    #1;
    chk("midrst_cx", cx0, 13'h0);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_sov", sov0, 1'b0);
    step();
    rst0 = 1'b0;
    step();
    idle0("midrst_rel", 13'h0);

    // Back-to-back: FF then A5 held valid
    d0 = 8'hFF; dv0 = 1'b1;
    step();
    d0 = 8'hA5;
    frame0("dff", 13'h1AFF);
    step();
    dv0 = 1'b0;
    frame0("da5", 13'h1BA5);
    step();
    idle0("b2b_end", 13'h1BA5);

    for (int i = 0; i < 4; i++) begin
      d0 = vec_d[i]; dv0 = 1'b1;
      step();
      dv0 = 1'b0;
      frame0($sformatf("vec%0d", i), vec_cw[i]);
      step();
    end

`ifdef ENC_ERR_INJECT_EN
    d0 = 8'h01; em0 = 13'h0001; dv0 = 1'b1;
    step();
    dv0 = 1'b0; em0 = '0;
    frame0("inj", 13'h1300);
    step();
    idle0("inj_end", 13'h1300);
`endif

    // Gap instance: abort mid-frame with reset
    d1 = 8'h01; dv1 = 1'b1;
    step();
    dv1 = 1'b0;
    chk("g_sof", sof1, 1'b1);
    chk("g_cx", cx1, 13'h1301);
    chk("g_first_msb", so1, 1'b1);
    repeat (6) step();
    chk("g_bit6_sov", sov1, 1'b1);
    rst1 = 1'b1;
    #1;
    chk("g_rst_cx", cx1, 13'h0);
    chk("g_rst_sov", sov1, 1'b0);
    chk("g_rst_busy", busy1, 1'b0);
    chk("g_rst_so", so1, 1'b0);
    step();
    rst1 = 1'b0;
    step();
    chk("g_rel_sov", sov1, 1'b0);
    chk("g_rel_busy", busy1, 1'b0);
    chk("g_rel_rdy", rdy1, 1'b1);

    // Clean frame, then 3 gap cycles; d_valid held with new data must be ignored
    d1 = 8'h01; dv1 = 1'b1;
    step();
    d1 = 8'hFF;
    frame1("gf", 13'h1301);
    for (int g = 0; g < 3; g++) begin
      step();
      chk($sformatf("gap%0d_sov", g), sov1, 1'b0);
      chk($sformatf("gap%0d_so", g), so1, 1'b0);
      chk($sformatf("gap%0d_busy", g), busy1, 1'b1);
      chk($sformatf("gap%0d_rdy", g), rdy1, 1'b0);
      chk($sformatf("gap%0d_cx", g), cx1, 13'h1301);
    end
    step();
    dv1 = 1'b0;
    chk("gap_end_busy", busy1, 1'b0);
    chk("gap_end_rdy", rdy1, 1'b1);
    chk("gap_end_cx", cx1, 13'h1301);
    step();
    chk("gap_idle_sov", sov1, 1'b0);
    chk("gap_idle_cx", cx1, 13'h1301);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
